// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: instruction-memory fetch handshake between pc_ctrl and imem.
interface pc_ctrl_if;
  logic        req;
  logic        ack;
  logic [31:0] addr;
  logic [31:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: two-state fetch controller owning the PC, with exception/eret redirects.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       npc,
  input  logic              stall,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [31:0]       epc,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              flush,
  pc_ctrl_if.master         imem
);
  typedef enum logic {REQ, VALID} state_t;
  state_t      state;
  logic        pend, pend_exc, redir, keep;
  logic [31:0] pend_tgt, new_tgt, tgt;
  assign imem.req    = state == REQ;
  assign imem.addr   = pc;
  assign instr_valid = state == VALID;
  always_comb begin
    redir   = exc_req | eret_req;
    new_tgt = exc_req ? EXC_VECTOR : epc & 32'hFFFF_FFFC;
    keep    = pend & pend_exc & ~exc_req;
    tgt     = (redir & ~keep) ? new_tgt : pend_tgt;
  end
  // redirects during an outstanding fetch wait for its ack, then replace the data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= REQ;
      pc       <= RESET_PC;
      instr    <= '0;
      flush    <= 1'b0;
      pend     <= 1'b0;
      pend_exc <= 1'b0;
      pend_tgt <= '0;
    end else begin
      flush <= redir;
      if (state == REQ) begin
        if (imem.ack && (pend || redir)) begin
          pc       <= tgt;
          pend     <= 1'b0;
          pend_exc <= 1'b0;
          pend_tgt <= '0;
        end else if (imem.ack) begin
          instr <= imem.rdata;
          state <= VALID;
        end else begin
          pend     <= pend | redir;
          pend_exc <= pend_exc | exc_req;
          pend_tgt <= tgt;
        end
      end else if (redir) begin
        pc    <= new_tgt;
        state <= REQ;
      end else if (!stall) begin
        pc    <= npc;
        state <= REQ;
      end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed checks of pc_ctrl fetch, stall, redirect and reset behaviour.
module tb_pc_ctrl;
  logic        clk = 0, reset = 0, stall = 0, exc_req = 0, eret_req = 0;
  logic [31:0] npc = '0, epc = '0, pc, instr;
  logic        instr_valid, flush;
  int          n_chk = 0, n_fail = 0;
  pc_ctrl_if imem();
  pc_ctrl dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .flush(flush), .imem(imem.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    imem.ack = 0;
    imem.rdata = '0;
    #1 reset = 1;
    #1;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_req", imem.req, 1);
    chk("rst_addr", imem.addr, 32'h3000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_instr", instr, 0);
    tick;
    reset = 0;
    imem.ack = 1;
    imem.rdata = 32'h3C01_0001;
    tick;
    imem.ack = 0;
    chk("fetch_instr", instr, 32'h3C01_0001);
    chk("fetch_valid", instr_valid, 1);
    chk("fetch_pc", pc, 32'h3000);
    chk("fetch_req", imem.req, 0);
    npc = 32'h3004;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_pc", pc, 32'h3000);
      chk("stall_req", imem.req, 0);
    end
    stall = 0;
    tick;
    chk("adv_pc", pc, 32'h3004);
    chk("adv_req", imem.req, 1);
    chk("adv_flush", flush, 0);
    imem.ack = 1;
    imem.rdata = 32'h11;
    tick;
    imem.ack = 0;
    exc_req = 1;
    eret_req = 1;
    tick;
    exc_req = 0;
    eret_req = 0;
    chk("both_pc", pc, 32'h4180);
    chk("both_flush", flush, 1);
    chk("both_req", imem.req, 1);
    tick;
    chk("both_flush_end", flush, 0);
    imem.ack = 1;
    imem.rdata = 32'h22;
    tick;
    imem.ack = 0;
    chk("vec_instr", instr, 32'h22);
    eret_req = 1;
    epc = 32'h3017;
    tick;
    eret_req = 0;
    chk("eret_pc", pc, 32'h3014);
    chk("eret_flush", flush, 1);
    tick;
    chk("eret_flush_end", flush, 0);
    eret_req = 1;
    epc = 32'h3100;
    tick;
    eret_req = 0;
    chk("pend_eret_flush", flush, 1);
    chk("pend_pc_hold", pc, 32'h3014);
    tick;
    chk("pend_flush_end", flush, 0);
    exc_req = 1;
    tick;
    exc_req = 0;
    chk("pend_exc_flush", flush, 1);
    imem.ack = 1;
    imem.rdata = 32'hFFFF_FFFF;
    tick;
    imem.ack = 0;
    chk("discard_pc", pc, 32'h4180);
    chk("discard_valid", instr_valid, 0);
    chk("discard_req", imem.req, 1);
    chk("discard_instr", instr, 32'h22);
    exc_req = 1;
    tick;
    exc_req = 0;
    eret_req = 1;
    epc = 32'h3100;
    tick;
    eret_req = 0;
    imem.ack = 1;
    imem.rdata = 32'h33;
    tick;
    imem.ack = 0;
    chk("exc_kept_pc", pc, 32'h4180);
    chk("exc_kept_valid", instr_valid, 0);
    eret_req = 1;
    epc = 32'h3200;
    imem.ack = 1;
    imem.rdata = 32'h44;
    tick;
    eret_req = 0;
    imem.ack = 0;
    chk("same_cyc_pc", pc, 32'h3200);
    chk("same_cyc_valid", instr_valid, 0);
    chk("same_cyc_flush", flush, 1);
    stall = 1;
    imem.ack = 1;
    imem.rdata = 32'h55;
    tick;
    imem.ack = 0;
    stall = 0;
    chk("req_stall_valid", instr_valid, 1);
    chk("req_stall_instr", instr, 32'h55);
    npc = 32'h3203;
    tick;
    chk("npc_pass_pc", pc, 32'h3203);
    #2 reset = 1;
    #1;
    chk("async_rst_pc", pc, 32'h3000);
    chk("async_rst_req", imem.req, 1);
    tick;
    reset = 0;
    imem.ack = 1;
    imem.rdata = 32'h66;
    tick;
    imem.ack = 0;
    chk("post_rst_instr", instr, 32'h66);
    chk("post_rst_pc", pc, 32'h3000);
    chk("post_rst_valid", instr_valid, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_4180, is the PC value loaded on exception entry.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 npc  input  32  sequential/branch/jump target from the next-PC unit.
REQ-006 stall  input  1  hazard stall; holds the current instruction.
REQ-007 exc_req  input  1  exception/interrupt redirect request.
REQ-008 eret_req  input  1  return-from-exception redirect request.
REQ-009 epc  input  32  exception return address.
REQ-010 imem_ack  input  1  instruction memory data-ready strobe.
REQ-011 imem_rdata  input  32  instruction memory read data.
REQ-012 pc  output  32  current PC register.
REQ-013 imem_req  output  1  instruction fetch request.
REQ-014 imem_addr  output  32  fetch address, always equal to pc.
REQ-015 instr  output  32  latched instruction.
REQ-016 instr_valid  output  1  instr is valid for the decode stage.
REQ-017 flush  output  1  one-cycle pipeline flush pulse.

Function
REQ-018 The FSM SHALL have exactly two states: REQ (fetch outstanding) and VALID (instruction held).
REQ-019 imem_req SHALL be 1 iff state is REQ; instr_valid SHALL be 1 iff state is VALID (Moore outputs).
REQ-020 In REQ with imem_ack=0, the block SHALL hold pc, instr, and state.
REQ-021 In REQ with imem_ack=1 and no pending redirect, the block SHALL latch imem_rdata into instr and move to VALID.
REQ-022 In VALID, requests SHALL be prioritised exc_req > eret_req > stall > advance.
REQ-023 VALID with exc_req=1: pc <= EXC_VECTOR, flush=1 next cycle, state -> REQ.
REQ-024 VALID with eret_req=1 and exc_req=0: pc <= {epc[31:2],2'b00}, flush=1 next cycle, state -> REQ.
REQ-025 VALID with stall=1 and no redirect: pc, instr, and state SHALL be held, with no fetch issued.
REQ-026 VALID with no stall and no redirect: pc <= npc, state -> REQ.
REQ-027 A redirect raised in REQ SHALL NOT abort the outstanding fetch; it SHALL be recorded in a pending-redirect flag plus a 32-bit target register, and flush SHALL pulse the next cycle.
REQ-028 Priority of pending redirects:
- a later exc_req SHALL overwrite a pending eret target;
- an eret_req SHALL NOT overwrite a pending exception target;
- simultaneous exc_req and eret_req SHALL record EXC_VECTOR.
REQ-029 In REQ with imem_ack=1 and a pending redirect: imem_rdata SHALL be discarded, pc <= pending target, pending cleared, state stays REQ.
REQ-030 A redirect in REQ in the same cycle as imem_ack=1 SHALL be treated as pending-then-consumed: data discarded, pc <= the new target, state REQ.
REQ-031 stall SHALL be ignored in REQ.
REQ-032 flush SHALL be a registered pulse exactly one cycle wide per accepted redirect, including back-to-back redirects.
REQ-033 With zero-wait memory (ack while req is high), steady-state throughput SHALL be one instruction per two cycles.
REQ-034 pc arithmetic SHALL be pass-through only; no alignment is applied except to epc.

Reset
REQ-035 On reset assertion, independent of clk, the block SHALL set:
- pc=RESET_PC and state=REQ (so imem_req=1 and imem_addr=RESET_PC);
- instr=0, instr_valid=0, flush=0;
- pending flag=0, pending target=0.
REQ-036 Reset asserted mid-fetch SHALL abandon the fetch, and any ack arriving after release SHALL be treated as the response to the RESET_PC fetch.

Verification
REQ-037 Reset, then ack with rdata=32'h3C01_0001 one cycle later -> instr=32'h3C01_0001, instr_valid=1, pc=32'h0000_3000.
REQ-038 VALID, npc=32'h0000_3004, stall=1 for 3 cycles then 0 -> pc holds 32'h0000_3000 for 3 cycles, then becomes 32'h0000_3004 with imem_req=1.
REQ-039 VALID with exc_req=1 and eret_req=1 together -> pc=32'h0000_4180, flush high for exactly one cycle, state REQ.
REQ-040 VALID with eret_req=1, epc=32'h0000_3017 -> pc=32'h0000_3014, flush pulse.
REQ-041 REQ with ack held low; eret (epc=32'h0000_3100) then exc on later cycles; then ack with rdata=32'hFFFF_FFFF -> data discarded, instr_valid stays 0, pc=32'h0000_4180, new fetch issued.
REQ-042 Reset pulsed while in REQ with ack low -> pc=32'h0000_3000 immediately, without waiting for a clk edge.
